// File: rtl/booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult
//  Description : Sequential signed multiplier, radix-2 Booth, one step per
//                clock. Hi/Lo hold the last full-width product.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Done,
    output logic             Busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_lastStep = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_accSum;
    logic [WIDTH:0]   w_accNext;
    logic [WIDTH-1:0] w_qNext;
    logic             w_lastStep;

    // Accumulator is one bit wider than the operands so -2^(WIDTH-1) is exact.
    always_comb begin
        w_accSum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_accSum = r_acc + r_m;
            2'b10:   w_accSum = r_acc - r_m;
            default: w_accSum = r_acc;
        endcase
    end

    assign w_accNext  = {w_accSum[WIDTH], w_accSum[WIDTH:1]};
    assign w_qNext    = {w_accSum[0], r_q[WIDTH-1:1]};
    assign w_lastStep = (r_count == c_lastStep);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_nextState = S_RUN;
            S_RUN:   if (w_lastStep) w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_m     <= {A[WIDTH-1], A};
                        r_acc   <= '0;
                        r_q     <= B;
                        r_q1    <= 1'b0;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_accNext;
                    r_q     <= w_qNext;
                    r_q1    <= r_q[0];
                    r_count <= r_count + c_one;
                    // Result registers move only here, so the old product stays readable.
                    if (w_lastStep) begin
                        r_hi <= w_accNext[WIDTH-1:0];
                        r_lo <= w_qNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Hi   = r_hi;
    assign Lo   = r_lo;
    assign Done = (r_state == S_DONE);
    assign Busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mult
//  Description : Self-checking bench for booth_mult against a plain signed
//                multiply reference, with timing and handshake checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult;

    localparam int WIDTH = 32;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Done;
    logic             Busy;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [63:0] lastProd   = '0;

    booth_mult #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Hi    (Hi),
        .Lo    (Lo),
        .Done  (Done),
        .Busy  (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Called just after an edge with the DUT idle. midStart > 0 pulses a
    // spurious Start at that RUN cycle; startInDone raises Start during DONE.
    task automatic doMult(input logic [31:0] a, input logic [31:0] b,
                          input int midStart, input bit startInDone);
        logic [63:0] want;
        int          k;
        int          busyCount;
        int          doneCount;
        bit          heldOk;
        want = refProduct(a, b);
        Start = 1'b1;
        A = a;
        B = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A = $urandom;
        B = $urandom;
        busyCount = Busy ? 1 : 0;
        heldOk    = ({Hi, Lo} === lastProd);
        doneCount = 0;
        k = 0;
        while (k < 40 && !Done) begin
            if (midStart > 0 && k == midStart) begin
                Start = 1'b1;
                A = $urandom;
                B = $urandom;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk);
            #1;
            k++;
            if (Busy) busyCount++;
            if (!Done && {Hi, Lo} !== lastProd) heldOk = 1'b0;
        end
        Start = 1'b0;
        checkVal("latency", 64'(k), 64'd32);
        checkVal("busyCycles", 64'(busyCount), 64'd33);
        checkVal("heldDuringRun", 64'(heldOk), 64'd1);
        checkVal("product", {Hi, Lo}, want);
        if (startInDone) begin
            Start = 1'b1;
            A = $urandom;
            B = $urandom;
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        if (Done) doneCount++;
        checkVal("doneWidth", 64'(doneCount), 64'd0);
        checkVal("idleAfterDone", 64'(Busy), 64'd0);
        checkVal("productHeld", {Hi, Lo}, want);
        lastProd = want;
    endtask

    logic [31:0] corners [6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001};

    initial begin
        int doneSeen;
        logic [31:0] ra;
        logic [31:0] rb;
        Reset = 1'b0;
        Start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge Clk);
        #1;
        checkVal("resetHiLo", {Hi, Lo}, 64'd0);
        checkVal("resetDone", 64'(Done), 64'd0);
        checkVal("resetBusy", 64'(Busy), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        doMult(32'd3, 32'd5, 0, 1'b0);
        doMult(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        doMult(32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        doMult(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b0);
        doMult(32'd0, 32'h1234, 0, 1'b0);

        // Spurious Start mid-run, then Start held through DONE into first IDLE edge.
        doMult(32'd6, 32'd7, 10, 1'b1);
        doMult(32'hFFFF_FFFE, 32'd9, 0, 1'b0);
        checkVal("minus2x9", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEE);

        // Reset in the middle of a multiply.
        Start = 1'b1;
        A = 32'd100;
        B = 32'd100;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        checkVal("midResetHiLo", {Hi, Lo}, 64'd0);
        checkVal("midResetDone", 64'(Done), 64'd0);
        checkVal("midResetBusy", 64'(Busy), 64'd0);
        lastProd = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (Done || Busy) doneSeen++;
        end
        checkVal("noDoneAfterReset", 64'(doneSeen), 64'd0);
        doMult(32'd2, 32'd3, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
            doMult(ra, rb, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
